// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types for the pipeline sequencing controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} ctrl_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) count_o <= '0;
    else if (inc_i && !(&count_o)) count_o <= count_o + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/redirect hazard control, EX forwarding and data-memory wait watchdog
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rs1_i,
  input  logic [4:0]       ex_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_regwrite_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_regwrite_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_regwrite_i,
  input  logic             ex_redirect_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic             freeze_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);
  ctrl_state_t state, state_nx;
  logic [WW-1:0] wcnt;
  logic lu, stall_inc, flush_inc;
  function automatic fwd_sel_t fwd_sel(input logic [4:0] rs);
    return (mem_regwrite_i && mem_rd_i != 5'd0 && mem_rd_i == rs) ? FWD_MEM :
           (wb_regwrite_i && wb_rd_i != 5'd0 && wb_rd_i == rs) ? FWD_WB : FWD_RF;
  endfunction
  assign fwd_a_o = fwd_sel(ex_rs1_i);
  assign fwd_b_o = fwd_sel(ex_rs2_i);
  assign lu = ex_is_load_i && ex_rd_i != 5'd0 &&
              ((id_use_rs1_i && ex_rd_i == id_rs1_i) || (id_use_rs2_i && ex_rd_i == id_rs2_i));
  // Freeze masks stall/flush so a pending hazard takes effect in the first unfrozen cycle.
  always_comb begin
    state_nx   = (state == RUN && dmem_req_i && !dmem_ack_i) ? MEM_WAIT :
                 (state == MEM_WAIT && dmem_ack_i) ? RUN :
                 (state == MEM_WAIT && wcnt == TMO) ? MEM_ERR : state;
    freeze_o   = (dmem_req_i && !dmem_ack_i) || (state == MEM_WAIT && !dmem_ack_i) || state == MEM_ERR;
    stall_inc  = !freeze_o && lu && !ex_redirect_i;
    flush_inc  = !freeze_o && ex_redirect_i;
    stall_if_o = stall_inc;
    stall_id_o = stall_inc;
    flush_id_o = flush_inc;
    flush_ex_o = stall_inc || flush_inc;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state     <= RUN;
      wcnt      <= '0;
      mem_err_o <= 1'b0;
    end else begin
      state     <= state_nx;
      wcnt      <= (state != MEM_WAIT) ? '0 : wcnt + 1'b1;
      mem_err_o <= mem_err_o || state_nx == MEM_ERR;
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk_i, .rst_ni, .inc_i(stall_inc), .count_o(stall_cnt_o));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk_i, .rst_ni, .inc_i(flush_inc), .count_o(flush_cnt_o));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, hazards, memory wait, timeout and saturation
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_ni;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load, mem_regwrite, wb_regwrite;
  logic ex_redirect, dmem_req, dmem_ack;
  logic stall_if, stall_id, flush_id, flush_ex, freeze, mem_err;
  logic [1:0] fwd_a, fwd_b;
  logic [2:0] stall_cnt, flush_cnt;
  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite),
    .ex_is_load_i(ex_is_load), .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
    .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite), .ex_redirect_i(ex_redirect),
    .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
    .stall_if_o(stall_if), .stall_id_o(stall_id), .flush_id_o(flush_id), .flush_ex_o(flush_ex),
    .freeze_o(freeze), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .mem_err_o(mem_err),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pipe();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load, mem_regwrite, wb_regwrite} = '0;
  endtask

  initial begin
    rst_ni = 1'b0;
    clear_pipe();
    {ex_redirect, dmem_req, dmem_ack} = '0;
    #1;
    chk("rst_freeze", freeze, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_flush_ex", flush_ex, 0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    ex_rs1 = 5; mem_rd = 5; mem_regwrite = 1; wb_rd = 5; wb_regwrite = 1; #1;
    chk("fwd_mem_beats_wb", fwd_a, 2'b10);
    mem_regwrite = 0; #1;
    chk("fwd_wb_only", fwd_a, 2'b01);
    ex_rs1 = 0; mem_rd = 0; wb_rd = 0; mem_regwrite = 1; #1;
    chk("fwd_x0", fwd_a, 2'b00);
    ex_rs2 = 7; wb_rd = 7; #1;
    chk("fwd_b_wb", fwd_b, 2'b01);
    clear_pipe();
    tick();
    ex_is_load = 1; ex_regwrite = 1; ex_rd = 6; id_rs2 = 6; id_use_rs2 = 1; id_rs1 = 6; #1;
    chk("lu_stall_if", stall_if, 1);
    chk("lu_stall_id", stall_id, 1);
    chk("lu_flush_ex", flush_ex, 1);
    chk("lu_flush_id", flush_id, 0);
    tick();
    ex_is_load = 0; ex_regwrite = 0; ex_rd = 0; mem_rd = 6; mem_regwrite = 1; #1;
    chk("lu_one_cycle", stall_if, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    tick();
    clear_pipe();
    ex_rs2 = 6; wb_rd = 6; wb_regwrite = 1; #1;
    chk("lu_fwd_b", fwd_b, 2'b01);
    tick();
    clear_pipe();
    ex_is_load = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1; ex_redirect = 1; #1;
    chk("redir_flush_id", flush_id, 1);
    chk("redir_flush_ex", flush_ex, 1);
    chk("redir_no_stall", stall_if, 0);
    tick();
    clear_pipe();
    ex_redirect = 0; #1;
    chk("redir_flush_cnt", flush_cnt, 1);
    chk("redir_stall_cnt", stall_cnt, 1);
    ex_redirect = 1; dmem_req = 1; #1;
    chk("wait_freeze0", freeze, 1);
    chk("wait_no_flush", flush_id, 0);
    tick();
    chk("wait_freeze1", freeze, 1);
    tick();
    chk("wait_freeze2", freeze, 1);
    chk("wait_flush_cnt_held", flush_cnt, 1);
    tick();
    dmem_ack = 1; #1;
    chk("ack_unfrozen", freeze, 0);
    chk("ack_flush_id", flush_id, 1);
    tick();
    {ex_redirect, dmem_req, dmem_ack} = '0; #1;
    chk("ack_flush_cnt", flush_cnt, 2);
    tick();
    chk("run_unfrozen", freeze, 0);
    dmem_req = 1;
    tick();
    chk("tmo_wait_start", mem_err, 0);
    repeat (4) tick();
    chk("tmo_not_yet", mem_err, 0);
    tick();
    chk("tmo_mem_err", mem_err, 1);
    dmem_req = 0; #1;
    chk("err_freeze", freeze, 1);
    tick();
    chk("err_sticky", mem_err, 1);
    #2 rst_ni = 1'b0; #1;
    chk("async_rst_freeze", freeze, 0);
    chk("async_rst_mem_err", mem_err, 0);
    chk("async_rst_flush_cnt", flush_cnt, 0);
    tick();
    rst_ni = 1'b1;
    ex_redirect = 1;
    repeat (7) tick();
    chk("sat_reach", flush_cnt, 7);
    repeat (2) tick();
    chk("sat_hold", flush_cnt, 7);
    ex_redirect = 0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
